// File: rtl/router_pkt_fifo.sv
// Packet FIFO between the router input FSM and one output port.
// Each entry carries a header tag; the read side tracks bytes remaining in the current packet.
module router_pkt_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sft_rst,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              hdr_out,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [AW:0]       level,
    output logic              pkt_active,
    output logic              pkt_done,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int unsigned RW      = DATA_W - 1;
    localparam int unsigned LW      = DATA_W - 2;
    localparam logic [AW:0] PtrOne  = (AW+1)'(1);
    localparam logic [AW:0] AfLevel = (AW+1)'(AF_THRESH);
    localparam logic [RW-1:0] RemOne = RW'(1);

    logic [DATA_W:0] mem [DEPTH];

    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     level_d;
    logic            lfd_q;
    logic [RW-1:0]   rem;
    logic            wr_acc;
    logic            rd_acc;
    logic [DATA_W:0] rd_entry;
    logic            rd_hdr;
    logic [LW-1:0]   rd_len;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pkt_active = (rem != '0);

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign rd_hdr   = rd_entry[DATA_W];
    assign rd_len   = rd_entry[DATA_W-1:2];

    // Acceptance uses pre-edge full/empty, so read+write on a full or empty FIFO is one-sided.
    always_comb begin
        wr_acc  = write_enb && !full;
        rd_acc  = read_enb && !empty;
        level_d = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level + PtrOne;
            2'b01:   level_d = level - PtrOne;
            default: level_d = level;
        endcase
    end

    // Storage needs no reset: an entry is never readable before it has been written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_q, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || sft_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            lfd_q       <= 1'b0;
            rem         <= '0;
            ovf_err     <= 1'b0;
            udf_err     <= 1'b0;
            data_out    <= '0;
            hdr_out     <= 1'b0;
            data_valid  <= 1'b0;
            pkt_done    <= 1'b0;
        end else begin
            lfd_q       <= lfd_state;
            level       <= level_d;
            almost_full <= (level_d >= AfLevel);
            ovf_err     <= ovf_err | (write_enb & full);
            udf_err     <= udf_err | (read_enb & empty);
            data_valid  <= rd_acc;
            pkt_done    <= 1'b0;

            if (wr_acc) begin
                wr_ptr <= wr_ptr + PtrOne;
            end

            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PtrOne;
                data_out <= rd_entry[DATA_W-1:0];
                hdr_out  <= rd_hdr;
                // A header always restarts the count, even mid-packet; orphan bytes leave it at 0.
                if (rd_hdr) begin
                    rem <= {1'b0, rd_len} + RemOne;
                end else if (rem == RemOne) begin
                    rem      <= '0;
                    pkt_done <= 1'b1;
                end else if (rem != '0) begin
                    rem <= rem - RemOne;
                end
            end else begin
                data_out <= '0;
                hdr_out  <= 1'b0;
            end
        end
    end

endmodule
